// File: rtl/nios_memory_dma_pkg.sv
// Shared types and constants for the nios_memory DMA engine.
package nios_memory_dma_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/nios_memory_dma_addr_gen.sv
// Source/destination pointers and remaining-word counter for the DMA engine.
module nios_memory_dma_addr_gen
  import nios_memory_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic [ADDR_W:0]   remaining,
  output logic              last
);

  // Pointers wrap naturally at 2^ADDR_W, so a full-size copy covers all of memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src;
      dst_ptr   <= dst;
      remaining <= len;
    end else if (step) begin
      src_ptr   <= src_ptr + ADDR_W'(1);
      dst_ptr   <= dst_ptr + ADDR_W'(1);
      remaining <= remaining - (ADDR_W+1)'(1);
    end
  end

  assign last = (remaining == (ADDR_W+1)'(1));

endmodule

// File: rtl/nios_memory_dma.sv
// Avalon-MM copy/fill engine for the nios_memory slave port.
// Optional running checksum of written words: define NIOS_MEMORY_DMA_CHECKSUM_EN.
module nios_memory_dma
  import nios_memory_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic [DATA_W-1:0] m_writedata,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata
);

  state_e            state, state_next;
  logic              mode_q;
  logic [DATA_W-1:0] pattern_q;
  logic              clken_q;
  logic              load, step, last;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [ADDR_W:0]   remaining;

  assign load = (state == IDLE) && start;
  assign step = (state == WR);

  nios_memory_dma_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .step      (step),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .src_ptr   (src_ptr),
    .dst_ptr   (dst_ptr),
    .remaining (remaining),
    .last      (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      mode_q    <= MODE_COPY;
      pattern_q <= '0;
      clken_q   <= 1'b0;
    end else begin
      state   <= state_next;
      clken_q <= 1'b1;
      if (load) begin
        mode_q    <= mode;
        pattern_q <= pattern;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) begin
        if (len == '0)              state_next = DONE;
        else if (mode == MODE_FILL) state_next = WR;
        else                        state_next = RD;
      end
      RD:   state_next = WR;
      WR: begin
        if (last)                     state_next = DONE;
        else if (mode_q == MODE_FILL) state_next = WR;
        else                          state_next = RD;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs decode straight from registered state; copy data is a
  // combinational pass-through of the read issued the cycle before.
  always_comb begin
    m_address    = '0;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_byteenable = 4'h0;
    m_writedata  = '0;
    case (state)
      RD: begin
        m_address    = src_ptr;
        m_chipselect = 1'b1;
        m_byteenable = BE_ALL;
      end
      WR: begin
        m_address    = dst_ptr;
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_byteenable = BE_ALL;
        m_writedata  = (mode_q == MODE_FILL) ? pattern_q : m_readdata;
      end
      default: ;
    endcase
  end

  assign busy    = (state == RD) || (state == WR);
  assign done    = (state == DONE);
  assign m_clken = clken_q;

`ifdef NIOS_MEMORY_DMA_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      sum_q <= '0;
    else if (load)     sum_q <= '0;
    else if (step)     sum_q <= sum_q + m_writedata;
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_nios_memory_dma.sv
// Directed bench for nios_memory_dma with a 1-cycle-latency memory model.
module tb_nios_memory_dma;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] src, dst;
  logic [ADDR_W:0]   len;
  logic [DATA_W-1:0] pattern;
  logic              busy, done;
  logic [DATA_W-1:0] checksum;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect, m_write, m_clken;
  logic [3:0]        m_byteenable;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;

  logic [DATA_W-1:0] mem [2048];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios_memory_dma #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .mode         (mode),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .pattern      (pattern),
    .busy         (busy),
    .done         (done),
    .checksum     (checksum),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_writedata  (m_writedata),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata)
  );

  // Memory model: single port, registered read data; bench preload port.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (m_clken && m_chipselect) begin
      if (m_write) mem[m_address] <= m_writedata;
      else         m_readdata <= mem[m_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    next_cycle();
    pre_we = 1'b0;
  endtask

  // Drives start during cycle 0 and returns at cycle 1.
  task automatic launch(input logic md, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                        input logic [ADDR_W:0] n, input logic [DATA_W-1:0] p);
    mode = md; src = s; dst = d; len = n; pattern = p; start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  function automatic logic [31:0] exp_sum(input logic [31:0] v);
`ifdef NIOS_MEMORY_DMA_CHECKSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    pattern = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset state
    #12;
    chk("rst_clken", {31'b0, m_clken}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_cs", {31'b0, m_chipselect}, 32'd0);
    chk("rst_be", {28'b0, m_byteenable}, 32'd0);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    chk("clken_up", {31'b0, m_clken}, 32'd1);
    chk("rst_checksum", checksum, 32'd0);

    // Fill 4 words of DEADBEEF at 16
    launch(1'b1, 11'd0, 11'd16, 12'd4, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      chk("fill_addr", {21'b0, m_address}, 32'd16 + 32'(i));
      chk("fill_wr", {30'b0, m_chipselect, m_write}, 32'd3);
      chk("fill_wd", m_writedata, 32'hDEADBEEF);
      chk("fill_be", {28'b0, m_byteenable}, 32'hF);
      chk("fill_busy", {31'b0, busy}, 32'd1);
      next_cycle();
    end
    chk("fill_done", {30'b0, done, busy}, 32'd2);
    chk("fill_sum", checksum, exp_sum(32'h7AB6FBBC));
    next_cycle();
    chk("fill_done_pulse", {31'b0, done}, 32'd0);
    for (int i = 0; i < 4; i++) chk("fill_mem", mem[16+i], 32'hDEADBEEF);

    // Copy 100..102 -> 200..202
    poke(11'd100, 32'd1); poke(11'd101, 32'd2); poke(11'd102, 32'd3);
    launch(1'b0, 11'd100, 11'd200, 12'd3, 32'h0);
    for (int k = 0; k < 3; k++) begin
      chk("copy_rd_addr", {21'b0, m_address}, 32'd100 + 32'(k));
      chk("copy_rd", {30'b0, m_chipselect, m_write}, 32'd2);
      next_cycle();
      chk("copy_wr_addr", {21'b0, m_address}, 32'd200 + 32'(k));
      chk("copy_wr", {30'b0, m_chipselect, m_write}, 32'd3);
      chk("copy_wd", m_writedata, 32'(k + 1));
      next_cycle();
    end
    chk("copy_done", {31'b0, done}, 32'd1);
    chk("copy_sum", checksum, exp_sum(32'd6));
    next_cycle();
    for (int k = 0; k < 3; k++) chk("copy_mem", mem[200+k], 32'(k + 1));

    // Wrap: 2046,2047,0 -> 10,11,12
    poke(11'd2046, 32'hA0A0A0A0); poke(11'd2047, 32'hB1B1B1B1); poke(11'd0, 32'hC2C2C2C2);
    launch(1'b0, 11'd2046, 11'd10, 12'd3, 32'h0);
    chk("wrap_rd0", {21'b0, m_address}, 32'd2046); next_cycle();
    chk("wrap_wr0", {21'b0, m_address}, 32'd10);   next_cycle();
    chk("wrap_rd1", {21'b0, m_address}, 32'd2047); next_cycle();
    chk("wrap_wr1", {21'b0, m_address}, 32'd11);   next_cycle();
    chk("wrap_rd2", {21'b0, m_address}, 32'd0);    next_cycle();
    chk("wrap_wr2", {21'b0, m_address}, 32'd12);   next_cycle();
    chk("wrap_done", {31'b0, done}, 32'd1);
    next_cycle();
    chk("wrap_mem10", mem[10], 32'hA0A0A0A0);
    chk("wrap_mem11", mem[11], 32'hB1B1B1B1);
    chk("wrap_mem12", mem[12], 32'hC2C2C2C2);

    // len = 0
    launch(1'b0, 11'd5, 11'd6, 12'd0, 32'h0);
    chk("zero_done", {29'b0, done, busy, m_chipselect}, 32'd4);
    next_cycle();
    chk("zero_idle", {29'b0, done, busy, m_chipselect}, 32'd0);

    // start while busy is ignored
    poke(11'd400, 32'h11111111);
    launch(1'b1, 11'd0, 11'd300, 12'd3, 32'h55);
    next_cycle();
    mode = 1'b0; dst = 11'd400; len = 12'd5; pattern = 32'h99; start = 1'b1;
    chk("busy_addr1", {21'b0, m_address}, 32'd301);
    next_cycle();
    start = 1'b0;
    chk("busy_addr2", {21'b0, m_address}, 32'd302);
    chk("busy_wd2", m_writedata, 32'h55);
    next_cycle();
    chk("busy_done", {31'b0, done}, 32'd1);
    chk("busy_sum", checksum, exp_sum(32'hFF));
    next_cycle();
    chk("busy_idle", {30'b0, busy, m_chipselect}, 32'd0);
    chk("busy_mem400", mem[400], 32'h11111111);
    chk("busy_mem302", mem[302], 32'h55);

    // Reset mid-copy
    poke(11'd500, 32'h5000); poke(11'd501, 32'h5001); poke(11'd601, 32'h22222222);
    launch(1'b0, 11'd500, 11'd600, 12'd4, 32'h0);
    next_cycle(); next_cycle();
    reset_n = 1'b0;
    #1;
    chk("abort_outs", {27'b0, busy, done, m_chipselect, m_write, m_clken}, 32'd0);
    chk("abort_addr", {21'b0, m_address}, 32'd0);
    chk("abort_wd", m_writedata, 32'd0);
    chk("abort_sum", checksum, 32'd0);
    chk("abort_mem600", mem[600], 32'h5000);
    chk("abort_mem601", mem[601], 32'h22222222);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    launch(1'b0, 11'd500, 11'd700, 12'd2, 32'h0);
    chk("post_rd", {21'b0, m_address}, 32'd500);
    next_cycle(); next_cycle(); next_cycle();
    chk("post_wr1", {21'b0, m_address}, 32'd701);
    next_cycle();
    chk("post_done", {31'b0, done}, 32'd1);
    chk("post_sum", checksum, exp_sum(32'hA001));
    next_cycle();
    chk("post_mem700", mem[700], 32'h5000);
    chk("post_mem701", mem[701], 32'h5001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
